// File: rtl/mix_columns_engine.sv
// mix_columns_engine: multi-cycle AES MixColumns / InvMixColumns unit.
// A 128-bit state is latched on handshake, mixed COLS_PER_CYCLE columns per
// clock in place, then presented on out_data until downstream accepts it.
module mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 1,
  parameter int BLOCK_W        = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic               in_inverse,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               busy
);

  // Reject unsupported configurations at elaboration time.
  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end
    if (BLOCK_W != 128) begin : g_bad_width
      $error("mix_columns_engine: BLOCK_W must be 128");
    end
  endgenerate

  // Counter advance per RUN cycle; 4 columns per cycle wraps straight to 0.
  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  // Counter value of the final column group in a block.
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_reg;
  logic [1:0]           cnt_reg;
  logic [BLOCK_W-1:0]   work_reg;
  logic                 mode_reg;
  logic [BLOCK_W-1:0]   work_next;

  // GF(2^8) multiply by 2 modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Mix one column word; forward circulant [2 3 1 1], inverse [14 11 13 9].
  function automatic logic [31:0] mix_col(input logic [31:0] w, input logic inv);
    logic [7:0] b  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m  [4];
    b[0] = w[31:24];
    b[1] = w[23:16];
    b[2] = w[15:8];
    b[3] = w[7:0];
    for (int i = 0; i < 4; i++) begin
      x2[i] = xt(b[i]);
      x4[i] = xt(x2[i]);
      x8[i] = xt(x4[i]);
    end
    for (int j = 0; j < 4; j++) begin
      if (inv)
        m[j] = (x8[j] ^ x4[j] ^ x2[j])
             ^ (x8[(j+1)%4] ^ x2[(j+1)%4] ^ b[(j+1)%4])
             ^ (x8[(j+2)%4] ^ x4[(j+2)%4] ^ b[(j+2)%4])
             ^ (x8[(j+3)%4] ^ b[(j+3)%4]);
      else
        m[j] = x2[j] ^ (x2[(j+1)%4] ^ b[(j+1)%4]) ^ b[(j+2)%4] ^ b[(j+3)%4];
    end
    return {m[0], m[1], m[2], m[3]};
  endfunction

  // One mixing lane per column handled in a cycle; column c sits at bit 96-32c.
  logic [1:0]  lane_idx [COLS_PER_CYCLE];
  logic [31:0] lane_out [COLS_PER_CYCLE];

  genvar gi;
  generate
    for (gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_lane
      assign lane_idx[gi] = cnt_reg + 2'(gi);
      assign lane_out[gi] = mix_col(work_reg[{~lane_idx[gi], 5'b0} +: 32], mode_reg);
    end
  endgenerate

  // Working register with the current column group replaced by its mixed value.
  always_comb begin
    work_next = work_reg;
    for (int g = 0; g < COLS_PER_CYCLE; g++)
      work_next[{~lane_idx[g], 5'b0} +: 32] = lane_out[g];
  end

  // Control FSM with registered handshake outputs and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
      work_reg  <= '0;
      mode_reg  <= 1'b0;
      out_data  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            work_reg  <= in_data;
            mode_reg  <= in_inverse;
            cnt_reg   <= 2'd0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          work_reg <= work_next;
          cnt_reg  <= cnt_reg + STEP;
          if (cnt_reg == LAST) begin
            out_data  <= work_next;
            out_valid <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mix_columns_engine.md
Name: mix_columns_engine

Overview:
- Multi-cycle, parametrised AES MixColumns unit with forward and inverse modes selected per block.
- Processes one 128-bit state, which is four 32-bit columns, in 4/COLS_PER_CYCLE cycles.
- Uses a valid/ready handshake on both input and output.
- Sits between the ShiftRows/SubBytes stages and AddRoundKey in the round datapath. Replaces the purely combinational inverse-only column mixer where area matters.

Parameters:
- COLS_PER_CYCLE, default 1: columns mixed per clock. Legal values are 1, 2 and 4. Any other value is an elaboration error.
- BLOCK_W, default 128: state width. Fixed at 128; any other value is an elaboration error. The parameter exists for interface checking only.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: reset, asynchronous and active-low.
- in_valid, input, 1: in_data and in_inverse are valid.
- in_ready, output, 1: engine can accept a block.
- in_data, input, 128: state; column 0 = [127:96] … column 3 = [31:0].
- in_inverse, input, 1: 0 = forward MixColumns, 1 = InvMixColumns. Sampled with in_data.
- out_valid, output, 1: out_data holds a finished block.
- out_ready, input, 1: downstream accepts out_data.
- out_data, output, 128: mixed state, same column/byte layout as in_data.
- busy, output, 1: high in RUN or DONE.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = IDLE; in_ready = 1; out_valid = 0; busy = 0.
  - out_data = 0; column counter = 0; working register = 0; latched mode = 0.
  - Reset asserted mid-operation abandons the block with no output. After deassertion the engine is in IDLE.
- Byte order within a column word w: b0 = w[31:24], b1 = w[23:16], b2 = w[15:8], b3 = w[7:0]. Result packs as {m0, m1, m2, m3}.
- Arithmetic is GF(2^8) with polynomial 0x11B.
  - xtime(x) = {x[6:0], 0} XOR (0x1B if x[7]).
  - Forward: m0 = 2b0 ^ 3b1 ^ b2 ^ b3, then rotate coefficients for m1..m3 (circulant [2 3 1 1]).
  - Inverse uses circulant [14 11 13 9]: m0 = 14b0 ^ 11b1 ^ 13b2 ^ 9b3, etc.
- FSM:
  - IDLE: in_ready = 1. On in_valid && in_ready at a rising edge:
    - latch in_data into the working register and in_inverse into the mode register;
    - counter = 0; go to RUN.
  - RUN: in_ready = 0. Each cycle:
    - mix columns counter .. counter+COLS_PER_CYCLE-1, using the latched mode;
    - write the results in place in the working register;
    - counter += COLS_PER_CYCLE.
    - When the last group is written (counter wraps to 0), copy the result to out_data and go to DONE.
  - DONE: out_valid = 1; out_data is held stable. On out_ready at a rising edge, go to IDLE; out_valid drops the same edge.
- Latency and throughput:
  - Handshake at edge T. out_valid is high after edge T + 4/COLS_PER_CYCLE.
  - Minimum block period is 4/COLS_PER_CYCLE + 2 cycles.
- in_valid while not IDLE is ignored; in_ready = 0 there. in_data and in_inverse may change freely after acceptance.
- out_ready while out_valid = 0 is ignored. Backpressure in DONE holds indefinitely with no data change.
- Counter width is 2 bits and wraps modulo 4. With COLS_PER_CYCLE = 4 the RUN state lasts exactly one cycle.
- Property: inverse(forward(x)) == x for all x.

Test Plan:
- Reset, then a single forward block with COLS_PER_CYCLE = 1:
  - stimulus: in_data = db135345_f20a225c_01010101_c6c6c6c6, in_inverse = 0, out_ready held 1;
  - required: out_data = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, with out_valid rising exactly 4 edges after the handshake;
  - required: in_ready low for 5 cycles.
- Inverse block:
  - stimulus: in_data = 8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, in_inverse = 1;
  - required: out_data = db135345_f20a225c_d4d4d4d5_2d26314c.
- Repeat both vectors with COLS_PER_CYCLE = 2 and 4:
  - required: identical data, with latency of 2 and 1 cycles respectively.
- Backpressure:
  - stimulus: hold out_ready = 0 for 10 cycles in DONE, and pulse in_valid with different data during that time;
  - required: out_data stable, out_valid stays 1, new data not accepted;
  - required: after out_ready = 1 for one edge, out_valid = 0 and in_ready = 1 the next cycle.
- Reset mid-RUN:
  - stimulus: assert rst_n = 0 at counter = 2, asynchronously, between edges;
  - required: out_valid = 0, out_data = 0 and in_ready = 1 immediately;
  - required: the next accepted block produces the correct result.
- Random round-trip:
  - stimulus: 1000 random blocks, forward then inverse, with random in_valid/out_ready gaps;
  - required: every block returns its original value and no block is dropped or duplicated.
